mpsoc_spram_arbiter: RTL and testbench

MPSOC_SPRAM_ARBITER -- requirements
Module: mpsoc_spram_arbiter

---
 rtl/mpsoc_spram_arbiter.sv | 141 ++++++++++++++
 tb/tb_mpsoc_spram_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_spram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port RAM.
// Combinational round-robin grant with a bounded lock, plus read-valid return tracking.
module mpsoc_spram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,

  input  logic                      ins_req_i,
  input  logic                      ins_lock_i,
  input  logic                      ins_we_i,
  input  logic [ADDR_WIDTH-1:0]     ins_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   ins_be_i,
  input  logic [DATA_WIDTH-1:0]     ins_data_i,
  output logic                      ins_gnt_o,
  output logic                      ins_rvalid_o,
  output logic [DATA_WIDTH-1:0]     ins_data_o,

  input  logic                      dat_req_i,
  input  logic                      dat_lock_i,
  input  logic                      dat_we_i,
  input  logic [ADDR_WIDTH-1:0]     dat_addr_i,
  input  logic [DATA_WIDTH/8-1:0]   dat_be_i,
  input  logic [DATA_WIDTH-1:0]     dat_data_i,
  output logic                      dat_gnt_o,
  output logic                      dat_rvalid_o,
  output logic [DATA_WIDTH-1:0]     dat_data_o,

  output logic                      req_o,
  output logic                      we_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic [DATA_WIDTH/8-1:0]   be_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  input  logic [DATA_WIDTH-1:0]     data_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

  // last: 0 = ins, 1 = dat. When prev_valid is set, last is also the previous-cycle owner.
  logic          last;
  logic          prev_valid;
  logic [CW-1:0] lock_cnt;
  logic          pend_rd;
  logic          rd_dat;

  logic own_req, own_lock, other_req, lock_act;
  logic gnt_ins, gnt_dat, gnt_any, locked_gnt;

  assign own_req   = last ? dat_req_i  : ins_req_i;
  assign own_lock  = last ? dat_lock_i : ins_lock_i;
  assign other_req = last ? ins_req_i  : dat_req_i;
  assign lock_act  = prev_valid & own_req & own_lock;

  always_comb begin
    gnt_ins    = 1'b0;
    gnt_dat    = 1'b0;
    locked_gnt = 1'b0;
    if (HRESETn) begin
      if (lock_act) begin
        // A starved peer breaks the lock once the owner has used its full quota.
        if (other_req && (lock_cnt == LOCK_LIMIT)) begin
          gnt_ins = last;
          gnt_dat = ~last;
        end else begin
          gnt_ins    = ~last;
          gnt_dat    = last;
          locked_gnt = 1'b1;
        end
      end else if (ins_req_i && dat_req_i) begin
        gnt_ins = last;
        gnt_dat = ~last;
      end else begin
        gnt_ins = ins_req_i;
        gnt_dat = dat_req_i;
      end
    end
  end

  assign gnt_any   = gnt_ins | gnt_dat;
  assign ins_gnt_o = gnt_ins;
  assign dat_gnt_o = gnt_dat;

  always_comb begin
    req_o  = 1'b0;
    we_o   = 1'b0;
    addr_o = '0;
    be_o   = '0;
    data_o = '0;
    if (gnt_ins) begin
      req_o  = 1'b1;
      we_o   = ins_we_i;
      addr_o = ins_addr_i;
      be_o   = ins_be_i;
      data_o = ins_data_i;
    end else if (gnt_dat) begin
      req_o  = 1'b1;
      we_o   = dat_we_i;
      addr_o = dat_addr_i;
      be_o   = dat_be_i;
      data_o = dat_data_i;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last       <= 1'b0;
      prev_valid <= 1'b0;
      lock_cnt   <= '0;
      pend_rd    <= 1'b0;
      rd_dat     <= 1'b0;
    end else begin
      prev_valid <= gnt_any;
      pend_rd    <= gnt_any & ~we_o;
      if (gnt_any) begin
        last <= gnt_dat;
      end
      if (gnt_any && !we_o) begin
        rd_dat <= gnt_dat;
      end
      // Saturates while the owner keeps the lock and nobody else is waiting.
      if (locked_gnt) begin
        lock_cnt <= (lock_cnt == LOCK_LIMIT) ? lock_cnt : lock_cnt + CW'(1);
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  assign ins_rvalid_o = pend_rd & ~rd_dat;
  assign dat_rvalid_o = pend_rd & rd_dat;
  assign ins_data_o   = data_i;
  assign dat_data_o   = data_i;

  logic [BE_WIDTH-1:0] be_unused;
  assign be_unused = '0;

endmodule

// File: tb/tb_mpsoc_spram_arbiter.sv
// Bench for mpsoc_spram_arbiter: hand-derived vector table, directed lock/reset
// sequences, and random traffic against a rule-level reference model.
module tb_mpsoc_spram_arbiter;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int LM = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ins_req, ins_lock, ins_we, dat_req, dat_lock, dat_we;
  logic [AW-1:0] ins_addr, dat_addr, addr_o;
  logic [BW-1:0] ins_be, dat_be, be_o;
  logic [DW-1:0] ins_wdata, dat_wdata, ins_rdata, dat_rdata, data_o, data_i;
  logic          ins_gnt, dat_gnt, ins_rvalid, dat_rvalid, req_o, we_o;

  int checks = 0;
  int errors = 0;

  mpsoc_spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .ins_req_i(ins_req), .ins_lock_i(ins_lock), .ins_we_i(ins_we),
    .ins_addr_i(ins_addr), .ins_be_i(ins_be), .ins_data_i(ins_wdata),
    .ins_gnt_o(ins_gnt), .ins_rvalid_o(ins_rvalid), .ins_data_o(ins_rdata),
    .dat_req_i(dat_req), .dat_lock_i(dat_lock), .dat_we_i(dat_we),
    .dat_addr_i(dat_addr), .dat_be_i(dat_be), .dat_data_i(dat_wdata),
    .dat_gnt_o(dat_gnt), .dat_rvalid_o(dat_rvalid), .dat_data_o(dat_rdata),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o),
    .data_i(data_i)
  );

  always #5 clk = ~clk;

  // Reference model: ports are 0 = ins, 1 = dat, -1 = none.
  int m_last, m_prev, m_streak, m_rv;

  task automatic model_reset();
    m_last = 0; m_prev = -1; m_streak = 0; m_rv = -1;
  endtask

  function automatic bit model_lock_on();
    if (m_prev == 0) return ins_req && ins_lock;
    if (m_prev == 1) return dat_req && dat_lock;
    return 1'b0;
  endfunction

  function automatic int model_pick();
    bit other_wants;
    if (model_lock_on()) begin
      other_wants = (m_prev == 0) ? dat_req : ins_req;
      if (m_streak >= LM && other_wants) return 1 - m_prev;
      return m_prev;
    end
    if (ins_req && dat_req) return 1 - m_last;
    if (ins_req) return 0;
    if (dat_req) return 1;
    return -1;
  endfunction

  task automatic model_commit();
    int g;
    bit wr;
    g = model_pick();
    if (g < 0) begin
      m_prev = -1; m_streak = 0; m_rv = -1;
    end else begin
      if (model_lock_on() && g == m_prev) m_streak = (m_streak < LM) ? m_streak + 1 : LM;
      else m_streak = 0;
      wr = (g == 0) ? ins_we : dat_we;
      m_rv = wr ? -1 : g;
      m_last = g;
      m_prev = g;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input int eg, input int erv, input string tag);
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_data;
    e_we = 1'b0; e_addr = '0; e_be = '0; e_data = '0;
    if (eg == 0) begin
      e_we = ins_we; e_addr = ins_addr; e_be = ins_be; e_data = ins_wdata;
    end else if (eg == 1) begin
      e_we = dat_we; e_addr = dat_addr; e_be = dat_be; e_data = dat_wdata;
    end
    check({tag, " ins_gnt"}, 64'(ins_gnt), 64'(eg == 0));
    check({tag, " dat_gnt"}, 64'(dat_gnt), 64'(eg == 1));
    check({tag, " req_o"}, 64'(req_o), 64'(eg >= 0));
    check({tag, " we_o"}, 64'(we_o), 64'(e_we));
    check({tag, " addr_o"}, 64'(addr_o), 64'(e_addr));
    check({tag, " be_o"}, 64'(be_o), 64'(e_be));
    check({tag, " data_o"}, 64'(data_o), 64'(e_data));
    check({tag, " ins_rvalid"}, 64'(ins_rvalid), 64'(erv == 0));
    check({tag, " dat_rvalid"}, 64'(dat_rvalid), 64'(erv == 1));
    check({tag, " ins_data_o"}, 64'(ins_rdata), 64'(data_i));
    check({tag, " dat_data_o"}, 64'(dat_rdata), 64'(data_i));
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic run_cycle(input int eg, input int erv, input string tag);
    @(negedge clk);
    check_outputs(eg, erv, tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_ports(input bit ir, input bit il, input bit iw,
                           input bit dr, input bit dl, input bit dw);
    ins_req = ir; ins_lock = il; ins_we = iw;
    dat_req = dr; dat_lock = dl; dat_we = dw;
    data_i = DW'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_ports(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit ir; bit il; bit iw;
    bit dr; bit dl; bit dw;
    int eg; int erv;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 0, 0, 1, 0, 0,  1, -1};
    tbl[1]  = '{1, 0, 0, 1, 0, 0,  0,  1};
    tbl[2]  = '{0, 0, 0, 1, 0, 0,  1,  0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, -1,  1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, -1, -1};
    tbl[5]  = '{1, 0, 0, 1, 0, 0,  0, -1};
    tbl[6]  = '{1, 0, 1, 0, 0, 0,  0,  0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, -1, -1};
    tbl[8]  = '{1, 0, 0, 1, 0, 0,  1, -1};
    tbl[9]  = '{1, 1, 0, 1, 0, 0,  0,  1};
    tbl[10] = '{1, 0, 0, 1, 1, 0,  1,  0};
    tbl[11] = '{1, 0, 0, 1, 0, 0,  0,  1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, -1,  0};

    model_reset();
    set_ports(0, 0, 0, 0, 0, 0);
    ins_addr = '0; dat_addr = 32'h10;
    ins_be = 2'b01; dat_be = 2'b11;
    ins_wdata = 16'hA5A5; dat_wdata = 16'h1234;

    // Requests during reset must see no grant and no memory activity.
    #2;
    set_ports(1, 1, 0, 1, 1, 0);
    #1;
    check_outputs(-1, -1, "in_reset");
    do_reset();

    for (int i = 0; i < 13; i++) begin
      set_ports(tbl[i].ir, tbl[i].il, tbl[i].iw, tbl[i].dr, tbl[i].dl, tbl[i].dw);
      ins_addr = 32'h100 + 32'(i);
      run_cycle(tbl[i].eg, tbl[i].erv, $sformatf("vec%0d", i));
    end

    // Lock fairness: ins holds req+lock, dat always requests.
    do_reset();
    ins_addr = 32'h200;
    for (int k = 0; k < 40; k++) begin
      set_ports(1, 1, 0, 1, 0, 0);
      run_cycle((k % 18 == 0) ? 1 : 0, (k == 0) ? -1 : (((k - 1) % 18 == 0) ? 1 : 0),
                $sformatf("lock%0d", k));
    end

    // Reset in the middle of a dat read.
    do_reset();
    set_ports(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("midrst dat_gnt", 64'(dat_gnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst gnt_off", 64'({ins_gnt, dat_gnt, req_o}), 64'd0);
    @(posedge clk); #1;
    check("midrst dat_rvalid", 64'(dat_rvalid), 64'd0);
    check("midrst ins_rvalid", 64'(ins_rvalid), 64'd0);
    rst_n = 1'b1;
    model_reset();
    set_ports(1, 0, 0, 1, 0, 0);
    run_cycle(1, -1, "midrst_tie");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int hold;
      hold = ((n / 64) % 2 == 1) ? 1 : 0;
      set_ports($urandom_range(0, 3) != 0,
                hold ? ($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) != 0,
                (!hold) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0);
      ins_addr = AW'($urandom); dat_addr = AW'($urandom);
      ins_be = BW'($urandom); dat_be = BW'($urandom);
      ins_wdata = DW'($urandom); dat_wdata = DW'($urandom);
      run_cycle(model_pick(), m_rv, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
